baw_match_tracker: RTL

- Parametrised successor to the fixed score/finish logic of the black-and-white card game.
- Accepts one played card pair per round, compares the cards and enforces single use of every card per player.
- Accumulates wins, losses and draws, counts rounds, and detects game end, then publishes the final game result.
- Sits between the FSM that drives the score-update pulse and the seven-segment/LED display logic.

---
 rtl/baw_match_tracker_if.sv | 35 +++
 rtl/baw_match_tracker.sv | 138 +++++++++++++
 2 files changed

// File: rtl/baw_match_tracker_if.sv
// Black-and-white card game match tracker bus: round-control and card inputs,
// score/finish outputs. The master modport drives plays; the slave modport is the tracker.
interface baw_match_tracker_if #(
    parameter int unsigned CARD_W    = 4,
    parameter int unsigned NUM_CARDS = 9,
    parameter int unsigned CNT_W     = 4
);
    logic                 start;
    logic                 clear;
    logic                 play_valid;
    logic [CARD_W-1:0]    p1_card;
    logic [CARD_W-1:0]    p2_card;
    logic [CNT_W-1:0]     round;
    logic [CNT_W-1:0]     win;
    logic [CNT_W-1:0]     lose;
    logic [CNT_W-1:0]     draw;
    logic [1:0]           matchresult;
    logic                 play_err;
    logic                 fin;
    logic [1:0]           game_result;
    logic [NUM_CARDS-1:0] p1_used;
    logic [NUM_CARDS-1:0] p2_used;

    modport master (
        output start, clear, play_valid, p1_card, p2_card,
        input  round, win, lose, draw, matchresult, play_err, fin, game_result,
               p1_used, p2_used
    );

    modport slave (
        input  start, clear, play_valid, p1_card, p2_card,
        output round, win, lose, draw, matchresult, play_err, fin, game_result,
               p1_used, p2_used
    );
endinterface

// File: rtl/baw_match_tracker.sv
// Match tracker for the black-and-white card game: validates each played card pair,
// enforces single use of every card, accumulates win/lose/draw/round counts and
// publishes the final result once the game ends.
// Optional build macro BAW_EARLY_DECIDE_EN: also end the game as soon as the outcome
// can no longer change with the rounds that remain.
module baw_match_tracker #(
    parameter int unsigned CARD_W     = 4,
    parameter int unsigned NUM_CARDS  = 9,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned WIN_TARGET = 5
) (
    input logic                clk,
    input logic                resetn,
    baw_match_tracker_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_round, r_win, r_lose, r_draw;
    logic [1:0]           r_matchresult;
    logic                 r_play_err;
    logic                 r_fin;
    logic [1:0]           r_game_result;
    logic [NUM_CARDS-1:0] r_p1_used, r_p2_used;

    logic [NUM_CARDS-1:0] w_p1_bit, w_p2_bit;
    logic                 w_legal, w_gt, w_lt, w_eq;
    logic [CNT_W-1:0]     w_round_n, w_win_n, w_lose_n, w_draw_n;
    logic                 w_decided, w_finish;
    logic [1:0]           w_game_result;
`ifdef BAW_EARLY_DECIDE_EN
    int unsigned          w_rem;
`endif

    // Legality of the offered pair and the post-update counters/finish it would produce.
    always_comb begin
        // Out-of-range cards shift past the mask and give an all-zero bit vector.
        w_p1_bit  = NUM_CARDS'(1) << bus.p1_card;
        w_p2_bit  = NUM_CARDS'(1) << bus.p2_card;
        w_legal   = (32'(bus.p1_card) < NUM_CARDS) && (32'(bus.p2_card) < NUM_CARDS) &&
                    ((r_p1_used & w_p1_bit) == '0) && ((r_p2_used & w_p2_bit) == '0);
        w_gt      = bus.p1_card > bus.p2_card;
        w_lt      = bus.p1_card < bus.p2_card;
        w_eq      = bus.p1_card == bus.p2_card;
        w_round_n = r_round + CNT_W'(1);
        w_win_n   = r_win + CNT_W'(w_gt);
        w_lose_n  = r_lose + CNT_W'(w_lt);
        w_draw_n  = r_draw + CNT_W'(w_eq);
`ifdef BAW_EARLY_DECIDE_EN
        w_rem     = NUM_CARDS - 32'(w_round_n);
        w_decided = (32'(w_win_n) > 32'(w_lose_n) + w_rem) ||
                    (32'(w_lose_n) > 32'(w_win_n) + w_rem);
`else
        w_decided = 1'b0;
`endif
        w_finish  = (32'(w_win_n) == WIN_TARGET) || (32'(w_lose_n) == WIN_TARGET) ||
                    (32'(w_round_n) == NUM_CARDS) || w_decided;
        if (w_win_n > w_lose_n) begin
            w_game_result = 2'b01;
        end else if (w_lose_n > w_win_n) begin
            w_game_result = 2'b10;
        end else begin
            w_game_result = 2'b11;
        end
    end

    // Game FSM with registered score state; clear and start both wipe the game first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_round       <= '0;
            r_win         <= '0;
            r_lose        <= '0;
            r_draw        <= '0;
            r_matchresult <= 2'b00;
            r_play_err    <= 1'b0;
            r_fin         <= 1'b0;
            r_game_result <= 2'b00;
            r_p1_used     <= '0;
            r_p2_used     <= '0;
        end else if (bus.clear || bus.start) begin
            // A start alongside a play drops the play silently.
            r_state       <= bus.clear ? ST_IDLE : ST_PLAY;
            r_round       <= '0;
            r_win         <= '0;
            r_lose        <= '0;
            r_draw        <= '0;
            r_matchresult <= 2'b00;
            r_play_err    <= 1'b0;
            r_fin         <= 1'b0;
            r_game_result <= 2'b00;
            r_p1_used     <= '0;
            r_p2_used     <= '0;
        end else begin
            r_play_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: ;
                ST_PLAY: begin
                    if (bus.play_valid) begin
                        if (w_legal) begin
                            r_round   <= w_round_n;
                            r_win     <= w_win_n;
                            r_lose    <= w_lose_n;
                            r_draw    <= w_draw_n;
                            r_p1_used <= r_p1_used | w_p1_bit;
                            r_p2_used <= r_p2_used | w_p2_bit;
                            r_matchresult <= w_gt ? 2'b01 : (w_lt ? 2'b10 : 2'b11);
                            if (w_finish) begin
                                r_state       <= ST_DONE;
                                r_fin         <= 1'b1;
                                r_game_result <= w_game_result;
                            end
                        end else begin
                            r_play_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.play_valid) begin
                        r_play_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.round       = r_round;
    assign bus.win         = r_win;
    assign bus.lose        = r_lose;
    assign bus.draw        = r_draw;
    assign bus.matchresult = r_matchresult;
    assign bus.play_err    = r_play_err;
    assign bus.fin         = r_fin;
    assign bus.game_result = r_game_result;
    assign bus.p1_used     = r_p1_used;
    assign bus.p2_used     = r_p2_used;
endmodule
